// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage pipeline: load-use stalls, branch flushes,
// multi-cycle MDU freeze/handshake and data-memory wait states.
module pipeline_hazard_ctrl #(
    parameter int unsigned MDU_MAX_CYCLES = 64,
    parameter int unsigned CNT_W          = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_memread,
    input  logic             ex_branch_taken,
    input  logic             ex_mdu_op,
    input  logic             mdu_done,
    input  logic             mem_stall,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             mem_wb_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_bubble,
    output logic             mdu_start,
    output logic             mdu_error,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int unsigned TW = $clog2(MDU_MAX_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN,
        LOAD_STALL,
        MDU_WAIT
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [TW-1:0]   r_tcnt;
    logic [TW-1:0]   w_tcnt_next;
    logic            r_err;
    logic            w_err_next;
    logic [CNT_W-1:0] r_stall;
    logic            w_load_use;

    assign w_load_use = id_ex_memread && (id_ex_rd != 5'd0) &&
                        ((id_uses_rs1 && (id_rs1 == id_ex_rd)) ||
                         (id_uses_rs2 && (id_rs2 == id_ex_rd)));

    // State register, timeout counter, sticky error and stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_tcnt  <= '0;
            r_err   <= 1'b0;
            r_stall <= '0;
        end else begin
            r_state <= w_next_state;
            r_tcnt  <= w_tcnt_next;
            r_err   <= w_err_next;
            if (!pc_write && (r_stall != '1))
                r_stall <= r_stall + 1'b1;
        end
    end

    // Next-state logic; a memory wait state freezes everything
    always_comb begin
        w_next_state = r_state;
        w_tcnt_next  = r_tcnt;
        w_err_next   = r_err;
        if (!mem_stall) begin
            unique case (r_state)
                RUN: begin
                    if (ex_branch_taken) begin
                        w_next_state = RUN;
                    end else if (ex_mdu_op) begin
                        w_next_state = MDU_WAIT;
                        w_tcnt_next  = '0;
                    end else if (w_load_use) begin
                        w_next_state = LOAD_STALL;
                    end
                end
                LOAD_STALL: w_next_state = RUN;
                MDU_WAIT: begin
                    if (mdu_done) begin
                        w_next_state = RUN;
                    end else begin
                        w_tcnt_next = r_tcnt + 1'b1;
                        if (r_tcnt == TW'(MDU_MAX_CYCLES - 1)) begin
                            w_next_state = RUN;
                            w_err_next   = 1'b1;
                        end
                    end
                end
                default: w_next_state = RUN;
            endcase
        end
    end

    // Output logic; reset forces a flushed, frozen pipeline asynchronously
    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        mem_wb_write  = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_bubble = 1'b0;
        mdu_start     = 1'b0;
        if (!rst_n) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_write  = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_bubble = 1'b1;
        end else if (mem_stall) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_write  = 1'b0;
        end else begin
            unique case (r_state)
                RUN: begin
                    if (ex_branch_taken) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (ex_mdu_op) begin
                        mdu_start     = 1'b1;
                        pc_write      = 1'b0;
                        if_id_write   = 1'b0;
                        id_ex_write   = 1'b0;
                        ex_mem_bubble = 1'b1;
                    end else if (w_load_use) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                    end
                end
                LOAD_STALL: begin
                end
                MDU_WAIT: begin
                    if (!mdu_done) begin
                        pc_write      = 1'b0;
                        if_id_write   = 1'b0;
                        id_ex_write   = 1'b0;
                        ex_mem_bubble = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mdu_error    = r_err;
    assign stall_cycles = r_stall;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + steered stimulus against a cycle-level reference model of the
// hazard rules; expected outputs are queued and checked by a separate monitor.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CNT_W   = 6;
    localparam int unsigned MDU_MAX = 64;
    localparam int          SAT     = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       memrd;
        logic       br;
        logic       mdu;
        logic       done;
        logic       mstall;
    } in_t;

    typedef struct packed {
        logic             pcw;
        logic             ifidw;
        logic             idexw;
        logic             exmemw;
        logic             memwbw;
        logic             ifidf;
        logic             idexf;
        logic             bub;
        logic             start;
        logic             err;
        logic [CNT_W-1:0] stall;
    } exp_t;

    typedef enum int { M_RUN, M_LOAD, M_MDU } mode_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    in_t  cur_in = '0;

    logic             pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
    logic             if_id_flush, id_ex_flush, ex_mem_bubble, mdu_start, mdu_error;
    logic [CNT_W-1:0] stall_cycles;

    pipeline_hazard_ctrl #(
        .MDU_MAX_CYCLES(MDU_MAX),
        .CNT_W         (CNT_W)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_rs1         (cur_in.rs1),
        .id_rs2         (cur_in.rs2),
        .id_uses_rs1    (cur_in.u1),
        .id_uses_rs2    (cur_in.u2),
        .id_ex_rd       (cur_in.rd),
        .id_ex_memread  (cur_in.memrd),
        .ex_branch_taken(cur_in.br),
        .ex_mdu_op      (cur_in.mdu),
        .mdu_done       (cur_in.done),
        .mem_stall      (cur_in.mstall),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .id_ex_write    (id_ex_write),
        .ex_mem_write   (ex_mem_write),
        .mem_wb_write   (mem_wb_write),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .ex_mem_bubble  (ex_mem_bubble),
        .mdu_start      (mdu_start),
        .mdu_error      (mdu_error),
        .stall_cycles   (stall_cycles)
    );

    always #5 clk = ~clk;

    // Reference model state
    mode_t m_mode   = M_RUN;
    int    m_waited = 0;
    logic  m_err    = 1'b0;
    int    m_stall  = 0;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic in_t mk(input int rs1, input int rs2, input bit u1, input bit u2,
                               input int rd, input bit memrd, input bit br, input bit mdu,
                               input bit done, input bit mstall);
        in_t x;
        x.rs1 = 5'(rs1); x.rs2 = 5'(rs2); x.u1 = u1; x.u2 = u2; x.rd = 5'(rd);
        x.memrd = memrd; x.br = br; x.mdu = mdu; x.done = done; x.mstall = mstall;
        return x;
    endfunction

    function automatic exp_t expect_out(input in_t x, input bit rst_on);
        exp_t e;
        bit   lu;
        e = '0;
        {e.pcw, e.ifidw, e.idexw, e.exmemw, e.memwbw} = 5'b11111;
        e.err   = m_err;
        e.stall = CNT_W'(m_stall);
        lu = x.memrd && (x.rd != 0) && ((x.u1 && x.rs1 == x.rd) || (x.u2 && x.rs2 == x.rd));
        if (!rst_on) begin
            {e.pcw, e.ifidw, e.idexw, e.exmemw, e.memwbw} = 5'b00000;
            {e.ifidf, e.idexf, e.bub} = 3'b111;
        end else if (x.mstall) begin
            {e.pcw, e.ifidw, e.idexw, e.exmemw, e.memwbw} = 5'b00000;
        end else if (m_mode == M_RUN) begin
            if (x.br) begin
                e.ifidf = 1'b1; e.idexf = 1'b1;
            end else if (x.mdu) begin
                e.start = 1'b1; e.pcw = 1'b0; e.ifidw = 1'b0; e.idexw = 1'b0; e.bub = 1'b1;
            end else if (lu) begin
                e.pcw = 1'b0; e.ifidw = 1'b0; e.idexf = 1'b1;
            end
        end else if (m_mode == M_MDU && !x.done) begin
            e.pcw = 1'b0; e.ifidw = 1'b0; e.idexw = 1'b0; e.bub = 1'b1;
        end
        return e;
    endfunction

    task automatic model_step(input in_t x);
        exp_t e;
        bit   lu;
        e  = expect_out(x, 1'b1);
        lu = !e.idexw ? 1'b0 : (!e.pcw && e.idexf);
        if (!e.pcw && m_stall < SAT) m_stall++;
        if (!x.mstall) begin
            case (m_mode)
                M_RUN: begin
                    if (x.br) m_mode = M_RUN;
                    else if (x.mdu) begin m_mode = M_MDU; m_waited = 0; end
                    else if (lu) m_mode = M_LOAD;
                end
                M_LOAD: m_mode = M_RUN;
                default: begin
                    if (x.done) m_mode = M_RUN;
                    else begin
                        m_waited++;
                        if (m_waited == MDU_MAX) begin m_mode = M_RUN; m_err = 1'b1; end
                    end
                end
            endcase
        end
    endtask

    task automatic edge_update();
        @(posedge clk);
        if (rst_n) model_step(cur_in);
    endtask

    task automatic drive(input in_t x);
        edge_update();
        #1;
        cur_in = x;
        exp_q.push_back(expect_out(x, 1'b1));
    endtask

    task automatic do_reset(input int n, input in_t held);
        edge_update();
        #1;
        rst_n = 1'b0;
        cur_in = held;
        m_mode = M_RUN; m_waited = 0; m_err = 1'b0; m_stall = 0;
        exp_q.push_back(expect_out(held, 1'b0));
        repeat (n - 1) begin
            @(posedge clk);
            #1;
            exp_q.push_back(expect_out(held, 1'b0));
        end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic rand_cycles(input int n, input int p_mdu, input int p_done, input int p_ms);
        repeat (n) begin
            drive(mk($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom), 1'($urandom),
                     $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                     $urandom_range(0, 99) < 10, $urandom_range(0, 99) < p_mdu,
                     $urandom_range(0, 99) < p_done, $urandom_range(0, 99) < p_ms));
        end
    endtask

    // Monitor: compares every DUT output cycle against the queued expectation
    initial begin
        exp_t e_exp, e_act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e_exp = exp_q.pop_front();
                e_act = {pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
                         if_id_flush, id_ex_flush, ex_mem_bubble, mdu_start, mdu_error,
                         stall_cycles};
                n_vec++;
                if (e_act !== e_exp)
                begin
                    n_err++;
                    $display("FAIL outputs @%0t: got %b_%b stall=%0d, exp %b_%b stall=%0d",
                             $time, e_act[CNT_W+9:CNT_W+5], e_act[CNT_W+4:CNT_W],
                             e_act.stall, e_exp[CNT_W+9:CNT_W+5], e_exp[CNT_W+4:CNT_W],
                             e_exp.stall);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        in_t q0;
        q0 = '0;
        do_reset(3, q0);
        // load-use on rs2, rd=0 / unused-source non-hazards, hazard masked by branch
        drive(mk(1, 5, 0, 1, 5, 1, 0, 0, 0, 0));
        drive(q0);
        drive(q0);
        drive(mk(0, 3, 1, 0, 0, 1, 0, 0, 0, 0));
        drive(mk(5, 0, 0, 0, 5, 1, 0, 0, 0, 0));
        drive(mk(2, 0, 1, 0, 2, 1, 1, 0, 0, 0));
        drive(q0);
        // MDU with done 5 cycles after start, done alongside start ignored
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        repeat (4) drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        drive(q0);
        // deferred start under mem_stall, then mem_stall during MDU_WAIT
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1));
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        repeat (2) drive(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0));
        repeat (3) drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1));
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
        drive(q0);
        // timeout
        repeat (70) drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        drive(q0);
        rand_cycles(400, 10, 15, 12);
        rand_cycles(300, 30, 0, 6);
        // reset mid-MDU_WAIT with a stale done held across release
        drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        repeat (3) drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        do_reset(2, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        repeat (3) drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        rand_cycles(400, 10, 20, 15);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, exp 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Sequences stalls, bubbles and flushes for the 5-stage RISC pipeline, working alongside the EX-stage forwarding muxes. Detects load-use hazards, taken branches, multi-cycle MDU (mul/div) operations in EX and data-memory wait states. Drives the write enables and flushes of the PC and pipeline registers, plus the MDU start/done handshake. Keeps a saturating stall-cycle counter for performance debug.

## Interface
- `MDU_MAX_CYCLES`, 64: MDU_WAIT cycles before timeout.
- `CNT_W`, 16: width of `stall_cycles`.
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `id_rs1`, `id_rs2` in 5 each: source registers of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2` in 1 each: the ID instruction actually reads that source.
- `id_ex_rd` in 5: destination of the instruction in EX.
- `id_ex_memread` in 1: the EX instruction is a load.
- `ex_branch_taken` in 1: branch/jump resolved taken in EX.
- `ex_mdu_op` in 1: EX holds a valid multi-cycle MDU op.
- `mdu_done` in 1: MDU result valid, single-cycle pulse.
- `mem_stall` in 1: data memory not ready.
- `pc_write`, `if_id_write`, `id_ex_write`, `ex_mem_write`, `mem_wb_write` out 1 each: register load enables.
- `if_id_flush`, `id_ex_flush` out 1 each: load a NOP into that register.
- `ex_mem_bubble` out 1: load a NOP into EX/MEM instead of the EX result.
- `mdu_start` out 1: one-cycle start pulse to the MDU.
- `mdu_error` out 1: sticky MDU timeout flag.
- `stall_cycles` out CNT_W: saturating count of front-end stall cycles.

## Operation
- States: RUN, LOAD_STALL, MDU_WAIT. Registered state. Outputs are combinational from the state and inputs.
- **Default (no event):** all `*_write` = 1. All flushes, `ex_mem_bubble` and `mdu_start` = 0.
- **Event priority:** `mem_stall` > `ex_branch_taken` > MDU > load-use. Only the highest-priority event takes effect.
- **Any state, `mem_stall` = 1:**
  - All five `*_write` = 0. No flush, no bubble, no `mdu_start`.
  - State, timeout counter and pending start are held.
  - `stall_cycles` increments.
- **RUN, branch taken:** `if_id_flush` = `id_ex_flush` = 1, `pc_write` = 1. Any load-use hazard is ignored. Stay in RUN.
- **RUN, `ex_mdu_op` = 1:**
  - `mdu_start` = 1.
  - `pc_write` = `if_id_write` = `id_ex_write` = 0, `ex_mem_bubble` = 1.
  - `mem_wb_write` = 1 so older instructions drain.
  - Clear the timeout counter. Go to MDU_WAIT.
- **RUN, load-use hazard:**
  - Hazard = `id_ex_memread` and `id_ex_rd` ≠ 0 and ((`id_uses_rs1` and `id_rs1` == `id_ex_rd`) or (`id_uses_rs2` and `id_rs2` == `id_ex_rd`)).
  - Response: `pc_write` = `if_id_write` = 0, `id_ex_flush` = 1. Go to LOAD_STALL.
- **LOAD_STALL:** default outputs, because the bubble now in EX cannot re-trigger. Unconditional return to RUN. Exactly one bubble per load-use.
- **MDU_WAIT, `mdu_done` = 0:**
  - Same freeze as MDU entry, but `mdu_start` = 0.
  - Counter increments. When it reaches `MDU_MAX_CYCLES`, set `mdu_error` and go to RUN with default outputs; the bubbled op is lost.
- **MDU_WAIT, `mdu_done` = 1:** default outputs, so the EX result is captured into EX/MEM. Go to RUN.
- `mdu_done` in RUN or LOAD_STALL is ignored. `ex_branch_taken` in MDU_WAIT is ignored.
- **`stall_cycles`:** +1 on every cycle with `pc_write` = 0. Saturates at all-ones.
- **`mdu_error`:** cleared only by reset.

## Timing
- **During reset (`rst_n` low, asynchronous):**
  - State RUN, counters 0, `mdu_error` = 0.
  - Outputs forced: all `*_write` = 0, `if_id_flush` = `id_ex_flush` = `ex_mem_bubble` = 1, `mdu_start` = 0.
  - Normal RUN outputs from the first rising edge after deassertion.
- **Reset mid-operation:** MDU_WAIT or LOAD_STALL is abandoned immediately. No `mdu_start` after release until a new `ex_mdu_op`.
- **Load-use latency:** hazard seen in cycle N → stall in N. Dependent instruction enters EX in N+2, where forwarding supplies the load data from MEM/WB.
- **MDU timing:**
  - Start in cycle N. Done arriving at N+k (k ≥ 1) releases the pipeline in N+k.
  - Total front-end stall = k cycles.
  - `mdu_done` in the same cycle as `mdu_start` is ignored.
- **`mem_stall` during MDU entry:** `mdu_start` is deferred. It is asserted on the first cycle with `mem_stall` = 0 while `ex_mdu_op` is still 1.

## Test plan
- Load x5 in EX, ID reads rs2 = x5 with `id_uses_rs2` = 1 → exactly one cycle of `pc_write` = 0 and `id_ex_flush` = 1, then RUN; `stall_cycles` = 1.
- Load with `id_ex_rd` = 0 and `id_rs1` = 0, or a match with `id_uses_rs1` = 0 → no stall.
- Load-use hazard and `ex_branch_taken` in the same cycle → both flushes asserted, `pc_write` = 1, no stall, no LOAD_STALL.
- `ex_mdu_op`, then `mdu_done` 5 cycles later → one `mdu_start` pulse, 5 stalled cycles with `ex_mem_bubble` = 1, release on the done cycle, `stall_cycles` = 5; no done for 64 cycles → `mdu_error` = 1, state RUN.
- `mem_stall` held 3 cycles during MDU_WAIT → all writes 0, timeout counter frozen; done after the stall releases normally.
- `rst_n` pulled low mid-MDU_WAIT → outputs take reset values immediately; after release, a stale `mdu_done` is ignored.
